// File: rtl/vgalb_pkg.sv
// Shared types and helpers for the ping-pong video line buffer.
package vgalb_pkg;

   typedef enum logic [1:0] {
      BS_EMPTY   = 2'd0,
      BS_FILLING = 2'd1,
      BS_FULL    = 2'd2,
      BS_READING = 2'd3
   } bank_st_e;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 2;

   function automatic bit rd_lat_legal(input int unsigned lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

   // Line length needs one extra bit so a completely full bank (2^AW) fits.
   function automatic int unsigned len_w(input int unsigned aw);
      return aw + 1;
   endfunction

endpackage

// File: rtl/vgalb_dpram.sv
// Simple dual-port RAM holding both banks; bank select is the address MSB.
module vgalb_dpram #(
   parameter int unsigned DW     = 24,
   parameter int unsigned AW     = 10,
   parameter int unsigned RD_LAT = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW:0]   waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW:0]   raddr,
   output logic [DW-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** (AW + 1);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] q1_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) q1_q <= mem[raddr];
   end

   // Optional second stage only advances behind a real read so the output holds.
   if (RD_LAT == 2) begin : g_lat2
      logic          re_q;
      logic [DW-1:0] q2_q;
      always_ff @(posedge clk) begin
         re_q <= re;
         if (re_q) q2_q <= q1_q;
      end
      assign rdata = q2_q;
   end else begin : g_lat1
      assign rdata = q1_q;
   end

endmodule

// File: rtl/vgalb_pp.sv
// Ping-pong video line buffer: writer fills one bank while scan-out reads the other.
module vgalb_pp
   import vgalb_pkg::*;
#(
   parameter int unsigned DW     = 24,
   parameter int unsigned AW     = 10,
   parameter int unsigned RD_LAT = 2
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_d,
   input  logic          wr_last,
   output logic          wr_ready,
   input  logic          rd_sol,
   input  logic          rd_en,
   output logic [DW-1:0] rd_q,
   output logic          rd_valid,
   output logic          rd_line_ok,
   output logic          ovf,
   output logic          unf,
   input  logic          flag_clr
);

   localparam int unsigned LW   = len_w(AW);
   localparam bit          LAT2 = rd_lat_legal(RD_LAT) ? (RD_LAT == 2) : 1'b1;

   bank_st_e        bst_q [2];
   bank_st_e        bst_d [2];
   logic [LW-1:0]   len_q [2];
   logic [LW-1:0]   len_d [2];
   logic [AW-1:0]   waddr_q, waddr_d;
   logic            wbank_q, wbank_d;
   logic            old_q, old_d;
   logic            rbank_q, rbank_d;
   logic [LW-1:0]   raddr_q, raddr_d;
   logic            wr_ready_q, wr_ready_d;
   logic            line_ok_q, line_ok_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;
   logic            rd_valid_q, sel_q;

   logic            filling, reading, wr_fire, rd_hit, rd_act, rd_bank;
   logic [LW-1:0]   rd_ptr;
   logic [AW:0]     ram_raddr;
   logic [DW-1:0]   ram_rdata;
   logic            v_end, h_end;

   // Bank bookkeeping; every decision looks only at state registered at cycle start.
   always_comb begin
      bst_d      = bst_q;
      len_d      = len_q;
      waddr_d    = waddr_q;
      wbank_d    = wbank_q;
      old_d      = old_q;
      rbank_d    = rbank_q;
      line_ok_d  = line_ok_q;
      wr_fire    = 1'b0;
      rd_hit     = 1'b0;
      ovf_d      = ovf_q & ~flag_clr;
      unf_d      = unf_q & ~flag_clr;

      filling    = (bst_q[wbank_q] == BS_FILLING);
      reading    = (bst_q[rbank_q] == BS_READING);
      rd_act     = reading;
      rd_bank    = rbank_q;
      rd_ptr     = raddr_q;

      if (wr_en && !filling) ovf_d = 1'b1;
      if (wr_en && filling) begin
         wr_fire = 1'b1;
         waddr_d = waddr_q + AW'(1);
         if (wr_last || (waddr_q == {AW{1'b1}})) begin
            bst_d[wbank_q] = BS_FULL;
            len_d[wbank_q] = LW'(waddr_q) + LW'(1);
            waddr_d        = '0;
            wbank_d        = ~wbank_q;
         end
      end else if (!filling && (bst_q[wbank_q] == BS_EMPTY)) begin
         bst_d[wbank_q] = BS_FILLING;
      end

      if (rd_sol) begin
         if (reading) bst_d[rbank_q] = BS_EMPTY;
         if (bst_q[old_q] == BS_FULL) begin
            bst_d[old_q] = BS_READING;
            rbank_d      = old_q;
            old_d        = ~old_q;
            line_ok_d    = 1'b1;
            rd_act       = 1'b1;
            rd_bank      = old_q;
            rd_ptr       = '0;
         end else begin
            line_ok_d    = 1'b0;
            unf_d        = 1'b1;
            rd_act       = 1'b0;
         end
      end

      rd_hit     = rd_en && rd_act && (rd_ptr < len_q[rd_bank]);
      raddr_d    = rd_hit ? (rd_ptr + LW'(1)) : rd_ptr;
      ram_raddr  = {rd_bank, rd_ptr[AW-1:0]};
      wr_ready_d = (bst_d[0] == BS_FILLING) || (bst_d[1] == BS_FILLING);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bst_q[0]   <= BS_FILLING;
         bst_q[1]   <= BS_EMPTY;
         len_q[0]   <= '0;
         len_q[1]   <= '0;
         waddr_q    <= '0;
         wbank_q    <= 1'b0;
         old_q      <= 1'b0;
         rbank_q    <= 1'b0;
         raddr_q    <= '0;
         wr_ready_q <= 1'b1;
         line_ok_q  <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         bst_q      <= bst_d;
         len_q      <= len_d;
         waddr_q    <= waddr_d;
         wbank_q    <= wbank_d;
         old_q      <= old_d;
         rbank_q    <= rbank_d;
         raddr_q    <= raddr_d;
         wr_ready_q <= wr_ready_d;
         line_ok_q  <= line_ok_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   vgalb_dpram #(
      .DW     (DW),
      .AW     (AW),
      .RD_LAT (LAT2 ? 2 : 1)
   ) u_ram (
      .clk   (sys_clk),
      .we    (wr_fire),
      .waddr ({wbank_q, waddr_q}),
      .wdata (wr_d),
      .re    (rd_hit),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Valid/hit delay matching the RAM read path.
   if (LAT2) begin : g_pipe2
      logic v1_q, h1_q;
      always_ff @(posedge sys_clk or posedge sys_rst) begin
         if (sys_rst) begin
            v1_q <= 1'b0;
            h1_q <= 1'b0;
         end else begin
            v1_q <= rd_en;
            h1_q <= rd_hit;
         end
      end
      assign v_end = v1_q;
      assign h_end = h1_q;
   end else begin : g_pipe1
      assign v_end = rd_en;
      assign h_end = rd_hit;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rd_valid_q <= 1'b0;
         sel_q      <= 1'b0;
      end else begin
         rd_valid_q <= v_end;
         if (v_end) sel_q <= h_end;
      end
   end

   assign wr_ready   = wr_ready_q;
   assign rd_valid   = rd_valid_q;
   assign rd_q       = sel_q ? ram_rdata : '0;
   assign rd_line_ok = line_ok_q;
   assign ovf        = ovf_q;
   assign unf        = unf_q;

endmodule

// File: tb/tb_vgalb_pp.sv
// Scoreboard bench for vgalb_pp against a line-FIFO reference model.
module tb_vgalb_pp;

   localparam int unsigned DW     = 24;
   localparam int unsigned AW     = 10;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned DEPTH  = 1 << AW;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic          wr_en = 1'b0, wr_last = 1'b0, rd_sol = 1'b0, rd_en = 1'b0, flag_clr = 1'b0;
   logic [DW-1:0] wr_d = '0;
   logic          wr_ready, rd_valid, rd_line_ok, ovf, unf;
   logic [DW-1:0] rd_q;

   int n_chk = 0;
   int n_err = 0;

   always #5 sys_clk = ~sys_clk;

   vgalb_pp #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .wr_en      (wr_en),
      .wr_d       (wr_d),
      .wr_last    (wr_last),
      .wr_ready   (wr_ready),
      .rd_sol     (rd_sol),
      .rd_en      (rd_en),
      .rd_q       (rd_q),
      .rd_valid   (rd_valid),
      .rd_line_ok (rd_line_ok),
      .ovf        (ovf),
      .unf        (unf),
      .flag_clr   (flag_clr)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: completed lines queue up FIFO-style; two banks in total.
   typedef struct {
      int unsigned   due;
      logic [DW-1:0] val;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] pix_fifo[$];
   logic [DW-1:0] fill_buf[$];
   logic [DW-1:0] rd_line[$];
   int unsigned   len_fifo[$];
   bit            m_fill = 1'b1, m_reading = 1'b0, m_ok = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
   logic [DW-1:0] m_lastq = '0;
   int unsigned   ecnt = 0;
   bit            s_fill, o_set, u_set;
   int unsigned   s_occ, s_fulln, n_pop;
   logic [DW-1:0] e_val;

   always @(posedge sys_clk or posedge sys_rst) begin
      ecnt++;
      if (sys_rst) begin
         exp_q.delete(); pix_fifo.delete(); fill_buf.delete(); rd_line.delete(); len_fifo.delete();
         m_fill = 1'b1; m_reading = 1'b0; m_ok = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_lastq = '0;
      end else begin
         s_fill  = m_fill;
         s_fulln = len_fifo.size();
         s_occ   = s_fulln + (m_reading ? 1 : 0);
         o_set   = 1'b0;
         u_set   = 1'b0;
         if (wr_en) begin
            if (s_fill) begin
               fill_buf.push_back(wr_d);
               if (wr_last || fill_buf.size() == DEPTH) begin
                  foreach (fill_buf[i]) pix_fifo.push_back(fill_buf[i]);
                  len_fifo.push_back(fill_buf.size());
                  fill_buf.delete();
                  m_fill = 1'b0;
               end
            end else begin
               o_set = 1'b1;
            end
         end
         if (!s_fill && s_occ < 2) m_fill = 1'b1;
         if (rd_sol) begin
            m_reading = 1'b0;
            rd_line.delete();
            if (s_fulln > 0) begin
               n_pop = len_fifo.pop_front();
               repeat (n_pop) rd_line.push_back(pix_fifo.pop_front());
               m_reading = 1'b1;
               m_ok      = 1'b1;
            end else begin
               m_ok  = 1'b0;
               u_set = 1'b1;
            end
         end
         if (rd_en) begin
            e_val = (m_reading && rd_line.size() > 0) ? rd_line.pop_front() : '0;
            exp_q.push_back('{due: ecnt + RD_LAT - 1, val: e_val});
         end
         m_ovf = o_set ? 1'b1 : (flag_clr ? 1'b0 : m_ovf);
         m_unf = u_set ? 1'b1 : (flag_clr ? 1'b0 : m_unf);
      end
   end

   // Monitor: compare registered outputs mid-cycle; pop read data when rd_valid is due.
   exp_t e_item;
   always @(negedge sys_clk) begin
      chk("wr_ready", 32'(wr_ready), 32'(m_fill));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("unf", 32'(unf), 32'(m_unf));
      chk("rd_line_ok", 32'(rd_line_ok), 32'(m_ok));
      if (exp_q.size() > 0 && exp_q[0].due == ecnt) begin
         e_item = exp_q.pop_front();
         chk("rd_valid", 32'(rd_valid), 32'd1);
         chk("rd_q", 32'(rd_q), 32'(e_item.val));
         m_lastq = e_item.val;
      end else begin
         chk("rd_valid_idle", 32'(rd_valid), 32'd0);
         chk("rd_q_hold", 32'(rd_q), 32'(m_lastq));
      end
   end

   task automatic step(input bit we, input logic [DW-1:0] d, input bit last,
                       input bit sol, input bit re, input bit clr);
      wr_en = we; wr_d = d; wr_last = last; rd_sol = sol; rd_en = re; flag_clr = clr;
      @(posedge sys_clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      idle(2);
      sys_rst = 1'b0;
      idle(1);
   endtask

   task automatic write_line(input int n, input logic [DW-1:0] base, input bit use_last);
      for (int i = 0; i < n; i++)
         step(1'b1, base + DW'(i), use_last && (i == n - 1), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic read_line(input int n);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(RD_LAT + 1);
   endtask

   initial begin
      do_reset();

      // Basic 4-pixel line, then one read past the end.
      write_line(4, DW'(1), 1'b1);
      read_line(5);

      // Both banks full, writer stalls, extra writes dropped, flag_clr.
      do_reset();
      write_line(3, DW'('h100), 1'b1);
      idle(2);
      write_line(3, DW'('h200), 1'b1);
      write_line(3, DW'('h300), 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, DW'('h3ff), 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      read_line(4);
      read_line(4);

      // Start of line with nothing to show.
      do_reset();
      step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);

      // Lines A then B read in order; A's bank reclaimed after release.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, DW'('h11), i == 4, 1'b0, 1'b0, 1'b0);
      idle(1);
      for (int i = 0; i < 5; i++) step(1'b1, DW'('h22), i == 4, 1'b0, 1'b0, 1'b0);
      read_line(5);
      read_line(5);
      write_line(2, DW'('h33), 1'b1);
      idle(2);

      // Line completes in the same cycle as rd_sol.
      do_reset();
      write_line(2, DW'('h40), 1'b0);
      step(1'b1, DW'('h42), 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      read_line(3);

      // Full-depth auto-complete, then reset in the middle of a read.
      do_reset();
      write_line(DEPTH, DW'('h5000), 1'b0);
      idle(1);
      read_line(DEPTH + 1);
      write_line(10, DW'('h6000), 1'b1);
      idle(1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      sys_rst = 1'b1;
      #1;
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_rd_q", 32'(rd_q), 32'd0);
      idle(2);
      sys_rst = 1'b0;
      idle(1);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 9) < 6, DW'($urandom), $urandom_range(0, 15) == 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      idle(RD_LAT + 3);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
